geet_fifo_wr_arbiter: RTL

GEET_FIFO_WR_ARBITER -- requirements
Module: geet_fifo_wr_arbiter

---
 rtl/geet_fifo_pkg.sv | 26 ++
 rtl/geet_rr_pick.sv | 41 ++++
 rtl/geet_fifo_wr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/geet_fifo_pkg.sv
// Shared state encoding and sizing helper for the geet FIFO write arbiter.
// Imported by the arbiter top and its round-robin picker.
package geet_fifo_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Ceiling log2, floored at one bit so single-entry ranges still get a port.
   function automatic int geet_clog2(input int value);
      int result;
      int span;
      result = 32'sd0;
      span   = 32'sd1;
      while (span < value) begin
         span   = span * 32'sd2;
         result = result + 32'sd1;
      end
      if (result == 32'sd0) begin
         result = 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/geet_rr_pick.sv
// Rotating-priority search: the first set request at or above start,
// wrapping modulo NUM_REQ, is granted.
module geet_rr_pick
   import geet_fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = geet_clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] sum_s;
   logic [IDX_W-1:0] cand_s;

   // Walk every slot once from start; the first hit wins and later hits are ignored.
   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      sum_s  = '0;
      cand_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum_s  = SUM_W'(start) + SUM_W'(i);
         cand_s = (sum_s >= SUM_W'(NUM_REQ)) ? IDX_W'(sum_s - SUM_W'(NUM_REQ))
                                             : IDX_W'(sum_s);
         if (!any && req[cand_s]) begin
            any           = 1'b1;
            idx           = cand_s;
            grant[cand_s] = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/geet_fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding many requesters into one external FIFO
// write port, with a one-cycle registered write pipeline.
module geet_fifo_wr_arbiter
   import geet_fifo_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            fifo_wr_en,
   output logic [DATA_WIDTH-1:0]           fifo_d_in,
   input  logic                            fifo_full,
   input  logic                            fifo_program_full,
   output logic [geet_clog2(NUM_REQ)-1:0]  grant_id,
   output logic                            busy
);

   localparam int IDX_W = geet_clog2(NUM_REQ);
   localparam int CNT_W = geet_clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
      return (cur == LAST_IDX) ? IDX_W'(0) : cur + IDX_W'(1);
   endfunction

   arb_state_e       state_r;
   arb_state_e       state_nxt_s;
   logic [IDX_W-1:0] owner_r;
   logic [IDX_W-1:0] owner_nxt_s;
   logic [CNT_W-1:0] beat_cnt_r;
   logic [CNT_W-1:0] beat_cnt_nxt_s;
   logic [IDX_W-1:0] rr_ptr_r;
   logic [IDX_W-1:0] rr_ptr_nxt_s;

   logic                  stall_s;
   logic [NUM_REQ-1:0]    pick_grant_s;
   logic [IDX_W-1:0]      pick_idx_s;
   logic                  pick_any_s;
   logic [NUM_REQ-1:0]    ready_s;
   logic                  xfer_s;
   logic [DATA_WIDTH-1:0] xfer_word_s;

   // program_full leaves room for the write already in the pipeline.
   assign stall_s   = fifo_full | fifo_program_full;
   assign req_ready = ready_s;
   assign xfer_s    = |(ready_s & req_valid);

   geet_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req_valid),
      .start (rr_ptr_r),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // Next-state, ownership, beat counting and the combinational ready vector.
   always_comb begin
      state_nxt_s    = state_r;
      owner_nxt_s    = owner_r;
      beat_cnt_nxt_s = beat_cnt_r;
      rr_ptr_nxt_s   = rr_ptr_r;
      ready_s        = '0;
      if (reset) begin
         ready_s = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!stall_s && pick_any_s) begin
                  ready_s        = pick_grant_s;
                  owner_nxt_s    = pick_idx_s;
                  beat_cnt_nxt_s = CNT_ONE;
                  if (BURST_LAST == CNT_ONE) begin
                     rr_ptr_nxt_s = next_idx(pick_idx_s);
                  end else begin
                     state_nxt_s = ST_BURST;
                  end
               end else begin
               end
            end
            ST_BURST: begin
               if (!req_valid[owner_r]) begin
                  state_nxt_s  = ST_IDLE;
                  rr_ptr_nxt_s = next_idx(owner_r);
               end else if (!stall_s) begin
                  ready_s[owner_r] = 1'b1;
                  beat_cnt_nxt_s   = beat_cnt_r + CNT_ONE;
                  if (beat_cnt_r + CNT_ONE == BURST_LAST) begin
                     state_nxt_s  = ST_IDLE;
                     rr_ptr_nxt_s = next_idx(owner_r);
                  end else begin
                  end
               end else begin
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // Select the word being accepted this cycle (ready is one-hot or zero).
   always_comb begin
      xfer_word_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ready_s[i]) begin
            xfer_word_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
         end
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         owner_r    <= '0;
         beat_cnt_r <= '0;
         rr_ptr_r   <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         owner_r    <= owner_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
         rr_ptr_r   <= rr_ptr_nxt_s;
         grant_id   <= (state_nxt_s == ST_BURST) ? owner_nxt_s : IDX_W'(0);
         busy       <= (state_nxt_s == ST_BURST);
      end
   end

   // Write pipeline: strobe every accepted word one cycle later, data holds otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_wr_en <= 1'b0;
         fifo_d_in  <= '0;
      end else begin
         fifo_wr_en <= xfer_s;
         if (xfer_s) begin
            fifo_d_in <= xfer_word_s;
         end else begin
            fifo_d_in <= fifo_d_in;
         end
      end
   end

endmodule
